fft_frame_scheduler: RTL and testbench
======================================

// Module: fft_frame_scheduler
// PURPOSE
//   Shares one 8-point radix-2 SDF FFT pipeline between NUM_ANT antenna frame buffers.
//   Round-robin arbitration between antennas with a complete frame ready.
//   Streams each granted frame to the FFT as N/2 contiguous sample pairs on data_0/data_1.
//   Tags every frame with its antenna id, so each FFT result frame is returned with its source.
// PARAMETERS
//   N          8  FFT size; one frame = N/2 beats of two complex_product_t samples
//   NUM_ANT    4  number of requesting antenna buffers (>=2)
//   TAG_DEPTH  4  max frames in flight inside the FFT (tag FIFO depth, power of 2)
// PORTS
//   clk             in   1        single clock, all logic posedge
//   reset_n         in   1        asynchronous, active-low reset
//   req             in   NUM_ANT  req[i]=1: buffer i holds >=1 full frame (first-word-fall-through)
//   ant_data_0      in   complex_product_t [NUM_ANT]  even sample at head of buffer i
//   ant_data_1      in   complex_product_t [NUM_ANT]  odd sample at head of buffer i
//   rd_en           out  NUM_ANT  one-hot pop of granted buffer, one pair per cycle
//   fft_data_0      out  complex_product_t  to FFT data_0 (registered)
//   fft_data_1      out  complex_product_t  to FFT data_1 (registered)
//   fft_enable      out  1        to FFT enable (registered, aligned with fft_data_*)
//   fft_out_valid   in   1        FFT out_valid; one-cycle pulse per finished frame
//   res_valid       out  1        result frame valid (= fft_out_valid when a tag is present)
//   res_ant_id      out  $clog2(NUM_ANT)  antenna id of current result frame
//   busy            out  1        FEED state active or tag FIFO non-empty
//   err_orphan      out  1        sticky: fft_out_valid arrived with the tag FIFO empty
// BEHAVIOUR
//   Reset: state=IDLE, rd_en=0, fft_enable=0, fft_data_*=0, tag FIFO empty, rr pointer=0.
//     Also res_valid=0, res_ant_id=0, busy=0, err_orphan=0.
//     Reset mid-frame abandons the frame immediately; the FFT is re-flushed by its own reset.
//   FSM: IDLE, FEED.
//   IDLE:
//     If |req and tag FIFO not full, pick a winner and push its id to the tag FIFO.
//     Winner = first requester at or after rr pointer, searching upward with wrap.
//     Load beat=0; next state FEED; rr pointer <= winner+1 (mod NUM_ANT).
//   FEED:
//     rd_en[winner]=1 (combinational from state/winner); beat increments each cycle.
//     Next cycle: fft_data_0/1 <= ant_data_0/1[winner] and fft_enable <= 1.
//     The FFT's gapless twiddle counter depends on the frame's N/2 enable cycles being contiguous; never stall.
//     At beat==N/2-1 (last beat), re-arbitrate with the IDLE rules.
//       If a winner exists, next FEED starts next cycle: back-to-back, no bubble.
//       Otherwise go to IDLE.
//   Outside FEED, fft_enable=0 next cycle and fft_data_* hold their last value.
//   Latency: req seen in IDLE at cycle t -> rd_en at t+1 -> first fft_enable at t+2.
//     A frame occupies exactly N/2 consecutive fft_enable cycles.
//   req[i] dropping mid-frame is ignored; the granted frame always completes (full-frame contract).
//   Tag FIFO: push at frame grant, pop on fft_out_valid.
//     Push and pop in the same cycle both take effect; count unchanged.
//     Full: no new grant; an in-progress frame still completes.
//     fft_out_valid with FIFO empty: no pop, res_valid=0, err_orphan<=1 until reset.
//   res_valid = fft_out_valid & ~empty; res_ant_id = FIFO head (combinational).
//   busy = (state==FEED) | ~empty.
// TESTING
//   1. Single frame: req=4'b0001, N=8 -> rd_en[0] for 4 cycles; fft_enable high 4 cycles starting t+2.
//      fft_data matches buffer 0; FFT pulse -> res_valid=1, res_ant_id=0.
//   2. All req=4'b1111 held -> grant order 0,1,2,3,0.
//      fft_enable stays high continuously with no bubbles between frames.
//   3. Fairness/wrap: last grant was 3, req=4'b1001 -> grant 0; next grant 3.
//   4. TAG_DEPTH=4 full with no fft_out_valid -> fifth grant withheld.
//      A pulse in the same cycle as the re-arbitration decision lets the grant proceed (push+pop).
//   5. fft_out_valid with empty FIFO -> res_valid=0, err_orphan=1 until reset_n low.
//   6. reset_n low at beat 2 -> rd_en, fft_enable, busy drop asynchronously.
//      After release, IDLE and a fresh frame restarts at beat 0.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Round-robin scheduler that streams complete antenna frames into one shared SDF FFT
// and tags each frame so FFT results come back labelled with their source antenna.
module fft_frame_scheduler #(
  parameter int unsigned N                 = 8,
  parameter int unsigned NUM_ANT           = 4,
  parameter int unsigned TAG_DEPTH         = 4,
  parameter type         complex_product_t = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_ANT-1:0]         req,
  input  complex_product_t           ant_data_0 [NUM_ANT],
  input  complex_product_t           ant_data_1 [NUM_ANT],
  output logic [NUM_ANT-1:0]         rd_en,
  output complex_product_t           fft_data_0,
  output complex_product_t           fft_data_1,
  output logic                       fft_enable,
  input  logic                       fft_out_valid,
  output logic                       res_valid,
  output logic [$clog2(NUM_ANT)-1:0] res_ant_id,
  output logic                       busy,
  output logic                       err_orphan
);

  localparam int unsigned AntW  = $clog2(NUM_ANT);
  localparam int unsigned Beats = N / 2;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned PtrW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(TAG_DEPTH + 1);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [AntW-1:0]  LastAnt  = AntW'(NUM_ANT - 1);
  localparam logic [CntW-1:0]  Depth    = CntW'(TAG_DEPTH);

  typedef enum logic [0:0] {StIdle, StFeed} state_e;

  state_e            state_q, state_d;
  logic [AntW-1:0]   winner_q;
  logic [BeatW-1:0]  beat_q;
  logic [AntW-1:0]   rr_q;

  logic [AntW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   tag_cnt_q;

  logic              arb_found;
  logic [AntW-1:0]   arb_pick;
  logic [AntW-1:0]   cand;
  logic              tag_empty, tag_full, pop, can_push;
  logic              last_beat, arb_window, grant;

  assign tag_empty  = (tag_cnt_q == '0);
  assign tag_full   = (tag_cnt_q == Depth);
  assign pop        = fft_out_valid & ~tag_empty;
  // A same-cycle result pop frees a slot, so a full FIFO does not block that grant.
  assign can_push   = ~tag_full | pop;
  assign last_beat  = (beat_q == LastBeat);
  assign arb_window = (state_q == StIdle) | ((state_q == StFeed) & last_beat);
  assign grant      = arb_window & arb_found & can_push;

  // First requester at or after the round-robin pointer, wrapping upward.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_ANT; k++) begin
      cand = AntW'((32'(rr_q) + k) % NUM_ANT);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StFeed;
      StFeed:  if (last_beat && !grant) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en = '0;
    if (state_q == StFeed) rd_en[winner_q] = 1'b1;
    busy       = (state_q == StFeed) | ~tag_empty;
    res_valid  = pop;
    res_ant_id = tag_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      winner_q   <= '0;
      beat_q     <= '0;
      rr_q       <= '0;
      fft_enable <= 1'b0;
      fft_data_0 <= '0;
      fft_data_1 <= '0;
    end else begin
      fft_enable <= (state_q == StFeed);
      if (state_q == StFeed) begin
        fft_data_0 <= ant_data_0[winner_q];
        fft_data_1 <= ant_data_1[winner_q];
      end
      if (grant) begin
        winner_q <= arb_pick;
        beat_q   <= '0;
        rr_q     <= (arb_pick == LastAnt) ? '0 : arb_pick + 1'b1;
      end else if (state_q == StFeed) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) begin
        tag_mem_q[wr_ptr_q] <= arb_pick;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (grant && !pop) begin
        tag_cnt_q <= tag_cnt_q + 1'b1;
      end else if (pop && !grant) begin
        tag_cnt_q <= tag_cnt_q - 1'b1;
      end
      if (fft_out_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench: antenna buffers and an FFT result pulser drive the scheduler, and a
// queue-based model of frames, tags and round-robin order predicts every output.
module tb_fft_frame_scheduler;

  localparam int N     = 8;
  localparam int NA    = 4;
  localparam int TD    = 4;
  localparam int BEATS = N / 2;

  typedef logic [31:0] cp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NA-1:0] req;
  cp_t           ant_data_0 [NA];
  cp_t           ant_data_1 [NA];
  logic [NA-1:0] rd_en;
  cp_t           fft_data_0, fft_data_1;
  logic          fft_enable, fft_out_valid, res_valid, busy, err_orphan;
  logic [1:0]    res_ant_id;

  always #5 clk = ~clk;

  fft_frame_scheduler #(
    .N                 (N),
    .NUM_ANT           (NA),
    .TAG_DEPTH         (TD),
    .complex_product_t (cp_t)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .ant_data_0    (ant_data_0),
    .ant_data_1    (ant_data_1),
    .rd_en         (rd_en),
    .fft_data_0    (fft_data_0),
    .fft_data_1    (fft_data_1),
    .fft_enable    (fft_enable),
    .fft_out_valid (fft_out_valid),
    .res_valid     (res_valid),
    .res_ant_id    (res_ant_id),
    .busy          (busy),
    .err_orphan    (err_orphan)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cp_t mk(input int ant, input int idx, input int odd);
    return {8'(ant), 24'(idx * 2 + odd)};
  endfunction

  // Antenna buffers: pairs available and pairs popped so far per antenna.
  int words [NA];
  int pop_cnt [NA];

  // Reference model: active frame, beats left, rr pointer, tags in flight.
  int   m_ant, m_left, m_rr;
  int   tq[$];
  int   exp_rd [NA];
  logic m_en, m_orph;
  cp_t  m_d0, m_d1;

  logic [NA-1:0] rd_s;
  bit            did_reset = 1'b0;

  task automatic drive_buffers();
    for (int i = 0; i < NA; i++) begin
      req[i]        = (words[i] >= BEATS);
      ant_data_0[i] = mk(i, pop_cnt[i], 0);
      ant_data_1[i] = mk(i, pop_cnt[i], 1);
    end
  endtask

  task automatic model_reset();
    m_ant  = -1;
    m_left = 0;
    m_rr   = 0;
    tq.delete();
    m_en   = 1'b0;
    m_d0   = '0;
    m_d1   = '0;
    m_orph = 1'b0;
    for (int i = 0; i < NA; i++) begin
      words[i]  = 0;
      exp_rd[i] = pop_cnt[i];
    end
  endtask

  task automatic check_outputs();
    check_eq("rd_en", 64'(rd_en), (m_ant >= 0) ? (64'd1 << m_ant) : 64'd0);
    check_eq("fft_enable", 64'(fft_enable), 64'(m_en));
    check_eq("fft_data_0", 64'(fft_data_0), 64'(m_d0));
    check_eq("fft_data_1", 64'(fft_data_1), 64'(m_d1));
    check_eq("busy", 64'(busy), 64'((m_ant >= 0) || (tq.size() > 0)));
    check_eq("res_valid", 64'(res_valid), 64'(fft_out_valid && (tq.size() > 0)));
    if (fft_out_valid && tq.size() > 0) check_eq("res_ant_id", 64'(res_ant_id), 64'(tq[0]));
    check_eq("err_orphan", 64'(err_orphan), 64'(m_orph));
  endtask

  // Advance the model across one rising edge using the inputs now presented.
  task automatic model_step();
    bit pop, can_push, decide, found;
    int w;
    pop      = fft_out_valid && (tq.size() > 0);
    can_push = (tq.size() < TD) || pop;
    decide   = (m_ant < 0) || (m_left == 1);
    if (fft_out_valid && tq.size() == 0) m_orph = 1'b1;
    m_en = (m_ant >= 0);
    if (m_ant >= 0) begin
      m_d0 = mk(m_ant, exp_rd[m_ant], 0);
      m_d1 = mk(m_ant, exp_rd[m_ant], 1);
      exp_rd[m_ant]++;
      m_left--;
      if (m_left == 0) m_ant = -1;
    end
    if (pop) void'(tq.pop_front());
    if (decide) begin
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < NA; k++) begin
        if (!found && req[(m_rr + k) % NA]) begin
          found = 1'b1;
          w     = (m_rr + k) % NA;
        end
      end
      if (found && can_push) begin
        m_ant  = w;
        m_left = BEATS;
        m_rr   = (w + 1) % NA;
        tq.push_back(w);
      end
    end
  endtask

  task automatic apply_pops(input logic [NA-1:0] rd);
    for (int i = 0; i < NA; i++) begin
      if (rd[i]) begin
        pop_cnt[i]++;
        words[i]--;
      end
    end
  endtask

  task automatic drive_random(input int cyc);
    int pa, pv, a;
    if (cyc < 300) begin
      pa = 30; pv = 10;
    end else if (cyc < 600) begin
      pa = 60; pv = 0;
    end else if (cyc < 1200) begin
      pa = 40; pv = 15;
    end else begin
      pa = 20; pv = 30;
    end
    if (cyc >= 10 && $urandom_range(99) < pa) begin
      a = $urandom_range(NA - 1);
      if (words[a] < 3 * BEATS) words[a] += BEATS;
    end
    fft_out_valid = (cyc == 4) || (cyc >= 10 && $urandom_range(99) < pv);
    drive_buffers();
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_rd_en", 64'(rd_en), 64'd0);
    check_eq("rst_fft_enable", 64'(fft_enable), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err_orphan", 64'(err_orphan), 64'd0);
    fft_out_valid = 1'b0;
    model_reset();
    drive_buffers();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    fft_out_valid = 1'b0;
    for (int i = 0; i < NA; i++) pop_cnt[i] = 0;
    model_reset();
    drive_buffers();
    #1;
    check_eq("init_rd_en", 64'(rd_en), 64'd0);
    check_eq("init_fft_enable", 64'(fft_enable), 64'd0);
    check_eq("init_fft_data_0", 64'(fft_data_0), 64'd0);
    check_eq("init_res_ant_id", 64'(res_ant_id), 64'd0);
    check_eq("init_busy", 64'(busy), 64'd0);
    check_eq("init_err_orphan", 64'(err_orphan), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (!did_reset && cyc >= 800 && m_ant >= 0 && m_left == 2) begin
        mid_reset();
        did_reset = 1'b1;
        continue;
      end
      rd_s = rd_en;
      model_step();
      @(posedge clk);
      #1;
      apply_pops(rd_s);
      drive_random(cyc);
    end
    check_eq("mid_frame_reset_reached", 64'(did_reset), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
